// File: rtl/tensor_mac_pkg.sv
// Shared types, constants and arithmetic helpers for the tensor MAC engine.
package tensor_mac_pkg;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t DRAIN = 1'b1;

  // Sums are formed at this width so the true value is always representable.
  localparam int unsigned WIDE_W = 64;

  function automatic int unsigned beats(input int unsigned acc_w, input int unsigned out_w);
    return acc_w / out_w;
  endfunction

  function automatic logic signed [WIDE_W-1:0] acc_max(input int unsigned acc_w);
    logic signed [WIDE_W-1:0] v;
    v = 64'sd1 << (acc_w - 1);
    return v - 64'sd1;
  endfunction

  function automatic logic signed [WIDE_W-1:0] acc_min(input int unsigned acc_w);
    logic signed [WIDE_W-1:0] v;
    v = 64'sd1 << (acc_w - 1);
    return 64'sd0 - v;
  endfunction

  function automatic logic out_of_range(input logic signed [WIDE_W-1:0] sum,
                                        input int unsigned acc_w);
    return (sum > acc_max(acc_w)) || (sum < acc_min(acc_w));
  endfunction

  function automatic logic signed [WIDE_W-1:0] saturate(input logic signed [WIDE_W-1:0] sum,
                                                        input int unsigned acc_w);
    if (sum > acc_max(acc_w)) return acc_max(acc_w);
    if (sum < acc_min(acc_w)) return acc_min(acc_w);
    return sum;
  endfunction

endpackage

// File: rtl/tensor_weight_buf.sv
// Circular weight register file with saturating valid-entry count.
module tensor_weight_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  // Storage is intentionally not reset; count gates which entries are meaningful.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (we) begin
      wr_ptr_q <= wr_ptr_q + IDX_W'(1);
      if (count_q != CNT_W'(DEPTH)) count_q <= count_q + CNT_W'(1);
    end
  end

  assign rdata = mem[raddr];
  assign count = count_q;

endmodule

// File: rtl/tensor_mac_engine.sv
// Signed MAC engine with weight buffer and beat-serial accumulator drain.
// Build option: define SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module tensor_mac_engine
  import tensor_mac_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        datos_in,
  input  logic                     ena_write,
  input  logic                     enable_accu,
  input  logic                     ena_read,
  input  logic                     clear,
  output logic [OUT_W-1:0]         datos_out,
  output logic                     ena_out,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   weight_count
);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned BEATS  = beats(ACC_W, OUT_W);
  localparam int unsigned BEAT_W = $clog2(BEATS + 1);
  localparam int unsigned PROD_W = 2 * DATA_W;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   snap_q;
  logic [IDX_W-1:0]   rd_idx_q;
  logic [BEAT_W-1:0]  beat_q;
  logic               ovf_q;
  logic [DATA_W-1:0]  weight_rd;

  logic idle, do_read, do_write, do_accu, rd_last;
  logic signed [PROD_W-1:0] din_x, w_x, prod;
  logic signed [WIDE_W-1:0] sum;
  logic [ACC_W-1:0]         acc_next;

  tensor_weight_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_weight_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (do_write),
    .wdata (datos_in),
    .raddr (rd_idx_q),
    .rdata (weight_rd),
    .count (weight_count)
  );

  // Priority clear > ena_read > ena_write > enable_accu; all but clear ignored while draining.
  assign idle     = (state_q == IDLE);
  assign do_read  = idle & ~clear & ena_read;
  assign do_write = idle & ~clear & ~ena_read & ena_write;
  assign do_accu  = idle & ~clear & ~ena_read & ~ena_write & enable_accu &
                    (weight_count != '0);
  assign rd_last  = ({1'b0, rd_idx_q} == (weight_count - CNT_W'(1)));

  assign din_x = PROD_W'($signed(datos_in));
  assign w_x   = PROD_W'($signed(weight_rd));
  assign prod  = din_x * w_x;
  assign sum   = WIDE_W'($signed(acc_q)) + WIDE_W'(prod);

`ifdef SATURATE_EN
  assign acc_next = ACC_W'(saturate(sum, ACC_W));
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      snap_q   <= '0;
      rd_idx_q <= '0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
    end else if (clear) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      snap_q   <= '0;
      rd_idx_q <= '0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_accu) begin
        acc_q    <= acc_next;
        rd_idx_q <= rd_last ? '0 : rd_idx_q + IDX_W'(1);
        if (out_of_range(sum, ACC_W)) ovf_q <= 1'b1;
      end
      if (do_read) begin
        state_q <= DRAIN;
        snap_q  <= acc_q;
        beat_q  <= '0;
      end else if (state_q == DRAIN) begin
        // Shift the snapshot so the current beat always sits in the low bits.
        snap_q <= snap_q >> OUT_W;
        beat_q <= beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(BEATS - 1)) state_q <= IDLE;
      end
    end
  end

  assign ena_out   = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign datos_out = ena_out ? snap_q[OUT_W-1:0] : '0;
  assign overflow  = ovf_q;

endmodule
